// File: rtl/mem_writeback.sv
// mem_writeback: memory-response and writeback stage of the three-stage RV32I
// pipeline. Captures the execute bundle, waits for the data-memory load
// response (stalling upstream while it is outstanding), formats load data,
// selects the writeback value and drives the register-file write port. Also
// holds the tohost CSR and a sticky response-timeout flag.
//
// Optional feature: define MEM_WB_PERF_CNT_EN to add the load_stall_count
// performance counter port (counts stall cycles, wraps at 2^32).
//
// TIMEOUT must be at least 1.

module mem_writeback #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_reg_we,
  input  logic        ex_mem_rr,
  input  logic        ex_csr_write,
  input  logic        ex_is_jump,
  input  logic [2:0]  ex_funct3,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_pc_plus4,
  input  logic        dmem_resp_valid,
  input  logic [31:0] dmem_resp_data,
  output logic        stall,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic [31:0] csr_tohost,
  output logic        resp_timeout
`ifdef MEM_WB_PERF_CNT_EN
  ,
  output logic [31:0] load_stall_count
`endif
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic        valid;
    logic        reg_we;
    logic        mem_rr;
    logic        csr_write;
    logic        is_jump;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
  } wb_t;

  state_e          state;
  state_e          state_nxt;
  wb_t             wb;
  logic            wait_clr;
  logic            wait_inc;
  logic [CW-1:0]   wait_cnt;
  logic [31:0]     load_data;
  logic            load_pending;

  // A load is outstanding whenever the captured instruction is a valid load.
  assign load_pending = wb.valid & wb.mem_rr;

  // Stall is purely combinational so it drops in the very cycle data arrives.
  assign stall = load_pending & ~dmem_resp_valid;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      // NOTE: sequential state always uses non-blocking (<=) so every flop
      // samples pre-edge values regardless of block ordering.
      state <= state_nxt;
    end
  end

  // Next-state logic: enter WAIT on a missing response, leave when it arrives.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    case (state)
      ST_RUN:  if (load_pending && !dmem_resp_valid) state_nxt = ST_WAIT;
      ST_WAIT: if (dmem_resp_valid)                  state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  // FSM outputs: the wait counter only advances on WAIT cycles still missing data.
  always_comb begin
    wait_clr = 1'b1;
    wait_inc = 1'b0;
    if (state == ST_WAIT && !dmem_resp_valid) begin
      wait_clr = 1'b0;
      wait_inc = 1'b1;
    end
  end

  // WB pipeline register: captures the execute bundle unless stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath fields are reset too (not just valid) so rf_wa/rf_wd
      // read 0 out of reset instead of X.
      wb <= '0;
    end else if (!stall) begin
      wb.valid      <= ex_valid;
      wb.reg_we     <= ex_reg_we;
      wb.mem_rr     <= ex_mem_rr;
      wb.csr_write  <= ex_csr_write;
      wb.is_jump    <= ex_is_jump;
      wb.funct3     <= ex_funct3;
      wb.rd         <= ex_rd;
      wb.alu_result <= ex_alu_result;
      wb.pc_plus4   <= ex_pc_plus4;
    end
  end

  // tohost CSR write, taken from the ALU result of a CSR-write instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_tohost <= '0;
    end else if (wb.valid && wb.csr_write) begin
      csr_tohost <= wb.alu_result;
    end
  end

  // Saturating wait counter and sticky timeout flag; waiting continues after timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt     <= '0;
      resp_timeout <= 1'b0;
    end else begin
      if (wait_clr) begin
        wait_cnt <= '0;
      end else if (wait_inc && wait_cnt != CW'(TIMEOUT)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (wait_inc && wait_cnt == CW'(TIMEOUT - 1)) begin
        resp_timeout <= 1'b1;
      end
    end
  end

  // Load alignment and extension from the low address bits.
  always_comb begin
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    case (wb.alu_result[1:0])
      2'd0:    byte_sel = dmem_resp_data[7:0];
      2'd1:    byte_sel = dmem_resp_data[15:8];
      2'd2:    byte_sel = dmem_resp_data[23:16];
      default: byte_sel = dmem_resp_data[31:24];
    endcase
    half_sel = wb.alu_result[1] ? dmem_resp_data[31:16] : dmem_resp_data[15:0];
    case (wb.funct3)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'h0, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'h0, half_sel};
      default: load_data = dmem_resp_data;
    endcase
  end

  // Writeback source select and register-file write port.
  always_comb begin
    if (wb.is_jump) begin
      rf_wd = wb.pc_plus4;
    end else if (wb.mem_rr) begin
      rf_wd = load_data;
    end else begin
      rf_wd = wb.alu_result;
    end
    rf_wa = wb.rd;
    rf_we = wb.valid & wb.reg_we & (wb.rd != 5'd0) & ~stall;
  end

`ifdef MEM_WB_PERF_CNT_EN
  // Performance counter: one count per stall cycle, free-running wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_stall_count <= '0;
    end else if (stall) begin
      load_stall_count <= load_stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_writeback.sv
// Self-checking bench for mem_writeback: reset values, a table of single
// instructions with scheduled responses, back-to-back, reset mid-WAIT,
// randomized traffic against a transaction-level model, and timeout.

module tb_mem_writeback;

  localparam int TOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_reg_we, ex_mem_rr, ex_csr_write, ex_is_jump;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic [31:0] ex_alu_result, ex_pc_plus4;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_data;
  logic        stall, rf_we, resp_timeout;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd, csr_tohost;
`ifdef MEM_WB_PERF_CNT_EN
  logic [31:0] load_stall_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mem_writeback #(.TIMEOUT(TOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_reg_we(ex_reg_we), .ex_mem_rr(ex_mem_rr),
    .ex_csr_write(ex_csr_write), .ex_is_jump(ex_is_jump),
    .ex_funct3(ex_funct3), .ex_rd(ex_rd),
    .ex_alu_result(ex_alu_result), .ex_pc_plus4(ex_pc_plus4),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data),
    .stall(stall), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .csr_tohost(csr_tohost), .resp_timeout(resp_timeout)
`ifdef MEM_WB_PERF_CNT_EN
    , .load_stall_count(load_stall_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        valid, reg_we, mem_rr, csr, jump;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] alu, pc4;
    int          delay;
    logic [31:0] data;
    logic        exp_we;
    logic [4:0]  exp_wa;
    logic [31:0] exp_wd;
    int          exp_stall;
    logic [31:0] exp_csr;
  } vec_t;

  typedef struct {
    logic        valid, reg_we, mem_rr, csr, jump;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] alu, pc4;
  } ins_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, we, rr, csr, jmp, input logic [2:0] f3,
                              input logic [4:0] rd, input logic [31:0] alu, pc4,
                              input int delay, input logic [31:0] data,
                              input logic exp_we, input logic [4:0] exp_wa,
                              input logic [31:0] exp_wd, input int exp_stall,
                              input logic [31:0] exp_csr);
    vec_t r;
    r.valid = v; r.reg_we = we; r.mem_rr = rr; r.csr = csr; r.jump = jmp;
    r.f3 = f3; r.rd = rd; r.alu = alu; r.pc4 = pc4; r.delay = delay; r.data = data;
    r.exp_we = exp_we; r.exp_wa = exp_wa; r.exp_wd = exp_wd;
    r.exp_stall = exp_stall; r.exp_csr = exp_csr;
    return r;
  endfunction

  // Reference load formatting from shift/mask arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
    logic [31:0] b, h;
    int unsigned bsh, hsh;
    bsh = 8 * int'(addr[1:0]);
    hsh = addr[1] ? 16 : 0;
    b = (word >> bsh) & 32'hFF;
    h = (word >> hsh) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128)   ? b - 32'd256     : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'h8000)  ? h - 32'h10000   : h;
      3'b101:  return h;
      default: return word;
    endcase
  endfunction

  task automatic drive_ins(input ins_t i);
    ex_valid = i.valid; ex_reg_we = i.reg_we; ex_mem_rr = i.mem_rr;
    ex_csr_write = i.csr; ex_is_jump = i.jump; ex_funct3 = i.f3; ex_rd = i.rd;
    ex_alu_result = i.alu; ex_pc_plus4 = i.pc4;
  endtask

  function automatic ins_t ins(input logic v, we, rr, csr, jmp, input logic [2:0] f3,
                               input logic [4:0] rd, input logic [31:0] alu, pc4);
    ins_t r;
    r.valid = v; r.reg_we = we; r.mem_rr = rr; r.csr = csr; r.jump = jmp;
    r.f3 = f3; r.rd = rd; r.alu = alu; r.pc4 = pc4;
    return r;
  endfunction

  // Leaves the bench at posedge+1 with reset released and inputs idle.
  task automatic do_reset();
    rst_n = 1'b0;
    drive_ins(ins(0, 0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0));
    dmem_resp_valid = 1'b0;
    dmem_resp_data  = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_stall"},   32'(stall), 32'd0);
    check({tag, "_rf_we"},   32'(rf_we), 32'd0);
    check({tag, "_rf_wa"},   32'(rf_wa), 32'd0);
    check({tag, "_rf_wd"},   rf_wd, 32'd0);
    check({tag, "_tohost"},  csr_tohost, 32'd0);
    check({tag, "_timeout"}, 32'(resp_timeout), 32'd0);
`ifdef MEM_WB_PERF_CNT_EN
    check({tag, "_perf"},    load_stall_count, 32'd0);
`endif
  endtask

  // Present one instruction, feed bubbles and a single response pulse at
  // cycle v.delay after capture, then check the writeback cycle.
  task automatic apply_vec(input int idx, input vec_t v);
    int  n_stall;
    bit  done;
    drive_ins(ins(v.valid, v.reg_we, v.mem_rr, v.csr, v.jump, v.f3, v.rd, v.alu, v.pc4));
    dmem_resp_valid = 1'b0;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    n_stall = 0;
    done = 1'b0;
    for (int c = 0; c < 16 && !done; c++) begin
      dmem_resp_valid = (c == v.delay);
      dmem_resp_data  = v.data;
      @(negedge clk);
      if (stall) begin
        n_stall++;
      end else begin
        done = 1'b1;
        check($sformatf("vec%0d_we", idx), 32'(rf_we), 32'(v.exp_we));
        if (v.exp_we) begin
          check($sformatf("vec%0d_wa", idx), 32'(rf_wa), 32'(v.exp_wa));
          check($sformatf("vec%0d_wd", idx), rf_wd, v.exp_wd);
        end
        check($sformatf("vec%0d_stalls", idx), n_stall, v.exp_stall);
      end
      @(posedge clk); #1;
      dmem_resp_valid = 1'b0;
    end
    if (!done) check($sformatf("vec%0d_wb_reached", idx), 32'd0, 32'd1);
    @(negedge clk);
    check($sformatf("vec%0d_tohost", idx), csr_tohost, v.exp_csr);
    @(posedge clk); #1;
  endtask

  vec_t vecs[18];

  initial begin
    ins_t cur, drv;
    logic [31:0] m_csr, exp_wd;
    logic exp_stall, exp_we, pending, resp;
    int run, m_stalls;

    do_reset();
    // Reset values while idle (rst_n held low again briefly).
    rst_n = 1'b0; #2;
    check_zero_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // ---------------- table-driven single instructions ----------------
    //            v we rr cs jp f3      rd  alu            pc4          dly data           we wa exp_wd        stl csr
    vecs[0]  = mk(1, 1, 0, 0, 0, 3'b000, 5,  32'h0000_1234, 32'h4,       99, 32'h0,         1, 5, 32'h0000_1234, 0, 0);
    vecs[1]  = mk(1, 1, 0, 0, 0, 3'b000, 0,  32'h0000_1234, 32'h4,       99, 32'h0,         0, 0, 32'h0,         0, 0);
    vecs[2]  = mk(1, 1, 1, 0, 0, 3'b000, 7,  32'h0000_0102, 32'h0,       3,  32'h80FF_7F01, 1, 7, 32'hFFFF_FFFF, 3, 0);
    vecs[3]  = mk(1, 1, 1, 0, 0, 3'b100, 7,  32'h0000_0102, 32'h0,       3,  32'h80FF_7F01, 1, 7, 32'h0000_00FF, 3, 0);
    vecs[4]  = mk(1, 1, 1, 0, 0, 3'b001, 7,  32'h0000_0102, 32'h0,       3,  32'h80FF_7F01, 1, 7, 32'hFFFF_80FF, 3, 0);
    vecs[5]  = mk(1, 1, 1, 0, 0, 3'b101, 7,  32'h0000_0102, 32'h0,       3,  32'h80FF_7F01, 1, 7, 32'h0000_80FF, 3, 0);
    vecs[6]  = mk(1, 1, 1, 0, 0, 3'b010, 3,  32'h0000_0100, 32'h0,       0,  32'hDEAD_BEEF, 1, 3, 32'hDEAD_BEEF, 0, 0);
    vecs[7]  = mk(1, 1, 0, 0, 1, 3'b000, 1,  32'h0000_5555, 32'h2004,    99, 32'h0,         1, 1, 32'h0000_2004, 0, 0);
    vecs[8]  = mk(1, 1, 1, 0, 0, 3'b000, 12, 32'h0000_0101, 32'h0,       1,  32'h80FF_7F01, 1, 12, 32'h0000_007F, 1, 0);
    vecs[9]  = mk(1, 1, 1, 0, 0, 3'b001, 13, 32'h0000_0101, 32'h0,       2,  32'h80FF_7F01, 1, 13, 32'h0000_7F01, 2, 0);
    vecs[10] = mk(1, 1, 1, 0, 0, 3'b011, 14, 32'h0000_0103, 32'h0,       0,  32'h1234_5678, 1, 14, 32'h1234_5678, 0, 0);
    vecs[11] = mk(1, 1, 1, 0, 0, 3'b111, 15, 32'h0000_0102, 32'h0,       1,  32'h8765_4321, 1, 15, 32'h8765_4321, 1, 0);
    vecs[12] = mk(1, 0, 0, 1, 0, 3'b000, 9,  32'h0000_0001, 32'h0,       99, 32'h0,         0, 9, 32'h0,         0, 1);
    vecs[13] = mk(1, 1, 0, 0, 0, 3'b000, 4,  32'hCAFE_0000, 32'h0,       0,  32'h1111_1111, 1, 4, 32'hCAFE_0000, 0, 1);
    vecs[14] = mk(0, 1, 1, 0, 0, 3'b010, 6,  32'h0000_0010, 32'h0,       99, 32'h0,         0, 6, 32'h0,         0, 1);
    vecs[15] = mk(1, 1, 1, 0, 0, 3'b000, 16, 32'h0000_0003, 32'h0,       0,  32'hA500_0000, 1, 16, 32'hFFFF_FFA5, 0, 1);
    vecs[16] = mk(1, 1, 1, 0, 0, 3'b100, 17, 32'h0000_0003, 32'h0,       0,  32'hA500_0000, 1, 17, 32'h0000_00A5, 0, 1);
    vecs[17] = mk(1, 1, 1, 0, 0, 3'b110, 18, 32'h0000_0000, 32'h0,       0,  32'h8000_0080, 1, 18, 32'h8000_0080, 0, 1);
    foreach (vecs[i]) apply_vec(i, vecs[i]);

    // ---------------- back-to-back LW then JAL ----------------
    drive_ins(ins(1, 1, 1, 0, 0, 3'b010, 5'd2, 32'h200, 32'h0));
    @(posedge clk); #1;
    drive_ins(ins(1, 1, 0, 0, 1, 3'b000, 5'd1, 32'h0, 32'h2004));
    dmem_resp_valid = 1'b1; dmem_resp_data = 32'h1122_3344;
    @(negedge clk);
    check("b2b_lw_stall", 32'(stall), 32'd0);
    check("b2b_lw_we",    32'(rf_we), 32'd1);
    check("b2b_lw_wa",    32'(rf_wa), 32'd2);
    check("b2b_lw_wd",    rf_wd, 32'h1122_3344);
    @(posedge clk); #1;
    ex_valid = 1'b0; dmem_resp_valid = 1'b0;
    @(negedge clk);
    check("b2b_jal_stall", 32'(stall), 32'd0);
    check("b2b_jal_we",    32'(rf_we), 32'd1);
    check("b2b_jal_wa",    32'(rf_wa), 32'd1);
    check("b2b_jal_wd",    rf_wd, 32'h0000_2004);
    @(posedge clk); #1;

    // ---------------- reset mid-WAIT with pending LW ----------------
    drive_ins(ins(1, 1, 1, 0, 0, 3'b010, 5'd10, 32'h300, 32'h0));
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(negedge clk);
    check("rstw_stall_run", 32'(stall), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstw_stall_wait", 32'(stall), 32'd1);
    #1 rst_n = 1'b0;
    #2;
    check_zero_outputs("rstw_in_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    dmem_resp_valid = 1'b1; dmem_resp_data = 32'h0000_0099;
    @(negedge clk);
    check("rstw_late_resp_stall", 32'(stall), 32'd0);
    check("rstw_late_resp_we",    32'(rf_we), 32'd0);
    @(posedge clk); #1;
    dmem_resp_valid = 1'b0;
    @(negedge clk);
    check("rstw_after_we", 32'(rf_we), 32'd0);
    @(posedge clk); #1;
    drive_ins(ins(1, 1, 0, 0, 0, 3'b000, 5'd11, 32'h77, 32'h0));
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(negedge clk);
    check("rstw_alu_we", 32'(rf_we), 32'd1);
    check("rstw_alu_wa", 32'(rf_wa), 32'd11);
    check("rstw_alu_wd", rf_wd, 32'h77);
    @(posedge clk); #1;

    // ---------------- randomized traffic vs transaction model ----------------
    // WB slot now holds a bubble; tohost and perf count are 0 since the reset.
    cur = ins(0, 0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0);
    m_csr = 32'd0; run = 0; m_stalls = 0;
    for (int n = 0; n < 400; n++) begin
      drv.valid  = ($urandom_range(0, 9) < 8);
      drv.mem_rr = ($urandom_range(0, 9) < 4);
      drv.csr    = !drv.mem_rr && ($urandom_range(0, 9) < 2);
      drv.jump   = !drv.mem_rr && !drv.csr && ($urandom_range(0, 9) < 2);
      drv.reg_we = !drv.csr && ($urandom_range(0, 9) < 8);
      drv.f3     = 3'($urandom_range(0, 7));
      drv.rd     = 5'($urandom_range(0, 31));
      drv.alu    = $urandom;
      drv.pc4    = $urandom;
      drive_ins(drv);
      pending = cur.valid && cur.mem_rr;
      resp    = ($urandom_range(0, 9) < 4) || (pending && run == 3);
      dmem_resp_valid = resp;
      dmem_resp_data  = $urandom;
      exp_stall = pending && !resp;
      exp_we    = cur.valid && cur.reg_we && (cur.rd != 5'd0) && !exp_stall;
      exp_wd    = cur.jump ? cur.pc4 : cur.mem_rr ? ref_load(cur.f3, cur.alu, dmem_resp_data) : cur.alu;
      @(negedge clk);
      check($sformatf("rnd%0d_stall", n), 32'(stall), 32'(exp_stall));
      check($sformatf("rnd%0d_we", n), 32'(rf_we), 32'(exp_we));
      if (exp_we) begin
        check($sformatf("rnd%0d_wa", n), 32'(rf_wa), 32'(cur.rd));
        check($sformatf("rnd%0d_wd", n), rf_wd, exp_wd);
      end
      check($sformatf("rnd%0d_tohost", n), csr_tohost, m_csr);
      check($sformatf("rnd%0d_timeout", n), 32'(resp_timeout), 32'd0);
      if (cur.valid && cur.csr) m_csr = cur.alu;
      if (exp_stall) begin
        run++;
        m_stalls++;
      end else begin
        run = 0;
        cur = drv;
      end
      @(posedge clk); #1;
    end
    dmem_resp_valid = 1'b0;
    ex_valid = 1'b0;
`ifdef MEM_WB_PERF_CNT_EN
    @(negedge clk);
    check("rnd_perf_count", load_stall_count, 32'(m_stalls));
    @(posedge clk); #1;
`endif

    // ---------------- timeout: response withheld for 6 cycles ----------------
    do_reset();
    drive_ins(ins(1, 1, 1, 0, 0, 3'b010, 5'd8, 32'h40, 32'h0));
    @(posedge clk); #1;
    ex_valid = 1'b0; dmem_resp_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("tout_stall_%0d", k), 32'(stall), 32'd1);
      // First stall cycle is in RUN, so TIMEOUT WAIT cycles complete after stall cycle TIMEOUT+1.
      check($sformatf("tout_flag_%0d", k), 32'(resp_timeout), 32'(k > TOUT + 1));
      @(posedge clk); #1;
    end
    dmem_resp_valid = 1'b1; dmem_resp_data = 32'h0BAD_F00D;
    @(negedge clk);
    check("tout_resp_stall", 32'(stall), 32'd0);
    check("tout_resp_we",    32'(rf_we), 32'd1);
    check("tout_resp_wa",    32'(rf_wa), 32'd8);
    check("tout_resp_wd",    rf_wd, 32'h0BAD_F00D);
    check("tout_resp_flag",  32'(resp_timeout), 32'd1);
    @(posedge clk); #1;
    dmem_resp_valid = 1'b0;
    @(negedge clk);
    check("tout_after_flag",  32'(resp_timeout), 32'd1);
    check("tout_after_stall", 32'(stall), 32'd0);
`ifdef MEM_WB_PERF_CNT_EN
    check("tout_perf_count", load_stall_count, 32'd6);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_writeback.md
# mem_writeback

Memory-response and writeback stage of the three-stage RV32I pipeline. It sits after execute and receives the control bundle produced by decode/read (`reg_we`, `mem_rr`, `csr_write`, `funct3`, `rd`) along with the execute results. It waits for the data-memory load response, aligns and extends the load data, and selects the writeback source. It drives the register-file write port, raises a pipeline stall while a load response is outstanding, and holds the `tohost` CSR.

## Interface
- `TIMEOUT`, default 255: number of consecutive wait cycles after which `resp_timeout` is raised.
- `clk  in  1`: clock, rising-edge.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `ex_valid  in  1`: execute stage holds a real instruction; 0 means bubble.
- `ex_reg_we  in  1`: instruction writes rd.
- `ex_mem_rr  in  1`: instruction is a load.
- `ex_csr_write  in  1`: instruction is a CSR write.
- `ex_is_jump  in  1`: JAL/JALR; writeback value is pc+4.
- `ex_funct3  in  3`: load width and signedness.
- `ex_rd  in  5`: destination register.
- `ex_alu_result  in  32`: ALU result, which is also the load address and the CSR write value.
- `ex_pc_plus4  in  32`: link value for jumps.
- `dmem_resp_valid  in  1`: load data is valid this cycle.
- `dmem_resp_data  in  32`: aligned word read from memory.
- `stall  out  1`: freeze every upstream stage this cycle.
- `rf_we  out  1`: register-file write enable.
- `rf_wa  out  5`: register-file write address.
- `rf_wd  out  32`: register-file write data. This port also serves as the forwarding source.
- `csr_tohost  out  32`: tohost CSR.
- `resp_timeout  out  1`: sticky error flag.
- `load_stall_count  out  32`: performance counter; present only when `MEM_WB_PERF_CNT_EN` is defined.

## Operation
- **WB register:** captures all `ex_*` inputs on a rising edge when `stall`=0. When `stall`=1 it holds. A bubble captures `wb_valid`=0.
- **FSM states:** RUN and WAIT.
  - RUN → WAIT when `wb_valid`, `wb_mem_rr` and `!dmem_resp_valid` are all true.
  - WAIT → RUN on `dmem_resp_valid`.
- **Stall:** `stall = wb_valid & wb_mem_rr & !dmem_resp_valid`. This is combinational and holds in both states. `stall` is 0 in the cycle the response arrives, so the next instruction is accepted on that edge.
- **Writeback source select:**
  - `wb_is_jump` → `pc_plus4`.
  - `wb_mem_rr` → formatted load data.
  - Otherwise → `alu_result`.
- **Write enable:** `rf_we = wb_valid & wb_reg_we & (wb_rd != 0) & !stall`. `rf_wa` = `wb_rd`.
- **Load formatting:** `a` = `alu_result[1:0]`.
  - LB (000) sign-extends byte `a`; LBU (100) zero-extends byte `a`.
  - LH (001) sign-extends halfword `a[1]`; LHU (101) zero-extends halfword `a[1]`. `a[0]` is ignored.
  - LW (010) and undefined codes (011, 110, 111) pass the full word.
- **CSR:** `csr_tohost <= wb_alu_result` on the edge ending a cycle with `wb_valid & wb_csr_write`. There is no register-file write for this instruction.
- **Stray responses:** `dmem_resp_valid` in a cycle with no pending load is ignored.
- **Timeout:** a wait counter clears in RUN and increments in each WAIT cycle, saturating.
  - When the count reaches `TIMEOUT`, `resp_timeout` is set. It stays set until reset.
  - The FSM keeps waiting; a late response completes normally.

## Timing
- **Reset values:** `stall`=0, `rf_we`=0, `rf_wa`=0, `rf_wd`=0, `csr_tohost`=0, `resp_timeout`=0, `load_stall_count`=0. State = RUN, `wb_valid`=0.
- **Non-load instruction:** latency is one cycle from capture to `rf_we`. The register file writes on the edge closing that cycle.
- **Load with same-cycle response:** zero stall cycles. Each cycle of missing response adds one stall cycle.
- **Reset mid-WAIT:** aborts the load. No write occurs, and a response arriving after reset is ignored.
- **Held outputs:** `rf_wd` and `rf_wa` are stable for the whole cycle in which `rf_we`=1.

## Configuration
- **`MEM_WB_PERF_CNT_EN` defined:** `load_stall_count` exists. It increments by 1 in every cycle with `stall`=1, wraps at 2^32 and resets to 0.
- **Macro undefined:** the port and the counter are absent. All other behaviour is identical.

## Test plan
- **Reset:** assert `rst_n`=0 mid-WAIT with a pending LW.
  - During reset, all outputs go to 0 and the state returns to RUN.
  - A response then arrives with `ex_valid`=0 (bubble in flight, no new load captured). Required: no write.
- **ALU write:** ALU op with `rd`=5, result 0x00001234.
  - Next cycle: `rf_we`=1, `rf_wa`=5, `rf_wd`=0x00001234.
  - Same op with `rd`=0: `rf_we`=0.
- **Byte/half loads:** load address 0x102, response 0x80FF7F01 after 3 cycles.
  - `stall` is high for exactly 3 cycles.
  - LB → 0xFFFFFFFF; LBU → 0x000000FF; LH → 0xFFFF80FF; LHU → 0x000080FF.
- **Back-to-back:** LW (response in the same cycle), then JAL with `pc_plus4`=0x2004 and `rd`=1.
  - No stall.
  - Consecutive writes: loaded word, then 0x00002004.
- **CSR:** `csr_write` with `alu_result`=0x00000001.
  - Next cycle: `csr_tohost`=1, `rf_we`=0.
- **Timeout:** set `TIMEOUT`=4 and withhold the response for 6 cycles.
  - `resp_timeout` rises after 4 WAIT cycles.
  - The response is then delivered, the write completes, and `resp_timeout` stays 1.
  - With `MEM_WB_PERF_CNT_EN` defined, `load_stall_count`=6.
